// File: rtl/reg_writeback_queue_pkg.sv
// Shared types for the register write-back queue: FSM states, the queued
// entry layout and the reserved zero-register index.
package wbq_pkg;

    localparam int WBQ_ADDR_W = 5;
    localparam int WBQ_DATA_W = 32;

    // Register 0 is hard-wired; writes to it are discarded and it never forwards.
    localparam logic [WBQ_ADDR_W-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic [WBQ_ADDR_W-1:0] addr;
        logic [WBQ_DATA_W-1:0] data;
    } entry_t;

endpackage

// File: rtl/reg_writeback_queue_if.sv
// Bus bundle between the WB stage / register-file readers (master) and the
// write-back queue (slave).
interface reg_writeback_queue_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = wbq_pkg::WBQ_DATA_W,
    parameter int ADDR_W = wbq_pkg::WBQ_ADDR_W
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Write-back request handshake
    logic              wb_valid;
    logic              wb_ready;
    logic [ADDR_W-1:0] wb_reg;
    logic [DATA_W-1:0] wb_data;

    // Register file write port
    logic              rf_busy;
    logic              regWrite;
    logic [ADDR_W-1:0] writeReg;
    logic [DATA_W-1:0] writeData;

    // Read-side forwarding lookup
    logic [ADDR_W-1:0] readReg1;
    logic [ADDR_W-1:0] readReg2;
    logic              fwd_hit1;
    logic              fwd_hit2;
    logic [DATA_W-1:0] fwd_data1;
    logic [DATA_W-1:0] fwd_data2;

    // Drain control and status
    logic              drain_req;
    logic              drain_done;
    logic [CNT_W-1:0]  occupancy;

    modport master (
        output wb_valid, wb_reg, wb_data, rf_busy, readReg1, readReg2, drain_req,
        input  wb_ready, regWrite, writeReg, writeData,
               fwd_hit1, fwd_hit2, fwd_data1, fwd_data2, drain_done, occupancy
    );

    modport slave (
        input  wb_valid, wb_reg, wb_data, rf_busy, readReg1, readReg2, drain_req,
        output wb_ready, regWrite, writeReg, writeData,
               fwd_hit1, fwd_hit2, fwd_data1, fwd_data2, drain_done, occupancy
    );

endinterface

// File: rtl/reg_writeback_queue_fwd_match.sv
// Forwarding lookup for one read port: finds the newest pending write to
// readReg among the queued entries and the register-file output stage.
// Only instanced when WBQ_FWD_EN is defined.
module wbq_fwd_match
    import wbq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  entry_t [DEPTH-1:0]      entries,
    input  logic   [PTR_W-1:0]      head,
    input  logic   [CNT_W-1:0]      count,
    input  logic                    outValid,
    input  logic   [WBQ_ADDR_W-1:0] outAddr,
    input  logic   [WBQ_DATA_W-1:0] outData,
    input  logic   [WBQ_ADDR_W-1:0] readReg,
    output logic                    hit,
    output logic   [WBQ_DATA_W-1:0] data
);

    logic [PTR_W-1:0] idx;

    // Walk candidates oldest to newest so the last match (the newest write) wins.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        if (readReg != REG_ZERO) begin
            if (outValid && (outAddr == readReg)) begin
                hit  = 1'b1;
                data = outData;
            end
            for (int i = 0; i < DEPTH; i++) begin
                idx = head + PTR_W'(i);
                if ((CNT_W'(i) < count) && (entries[idx].addr == readReg)) begin
                    hit  = 1'b1;
                    data = entries[idx].data;
                end
            end
        end
    end

endmodule

// File: rtl/reg_writeback_queue.sv
// Register write-back queue: buffers WB-stage writes, issues at most one
// register-file write per cycle, supports a drain handshake and (optionally)
// forwards pending data to two read ports.
// Build option: define WBQ_FWD_EN to enable forwarding; otherwise the
// forwarding outputs are tied to zero and readers must stall on occupancy.
module reg_writeback_queue
    import wbq_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = WBQ_DATA_W,
    parameter int ADDR_W = WBQ_ADDR_W
) (
    input  logic                 clock_in,
    input  logic                 reset,
    reg_writeback_queue_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    entry_t [DEPTH-1:0] mem;
    logic   [PTR_W-1:0] head;
    logic   [PTR_W-1:0] tail;
    logic   [CNT_W-1:0] count;
    state_t             state;
    state_t             stateNext;

    logic               regWriteQ;
    logic [ADDR_W-1:0]  writeRegQ;
    logic [DATA_W-1:0]  writeDataQ;

    logic               wbReady;
    logic               push;
    logic               pop;

    // A full queue never accepts, even when it is dequeuing in the same cycle.
    assign wbReady = (state == RUN) && (count < CNT_W'(DEPTH));
    // Writes to register 0 complete the handshake but are not stored.
    assign push    = bus.wb_valid && wbReady && (bus.wb_reg != REG_ZERO);
    assign pop     = (count != '0) && !bus.rf_busy;

    // Store an accepted request in the tail slot.
    // NOTE: the entry storage is deliberately not reset; count/head/tail define which slots are live, so stale contents are never observed.
    always_ff @(posedge clock_in) begin
        if (push) begin
            mem[tail] <= '{addr: bus.wb_reg, data: bus.wb_data};
        end
    end

    // Advance the FIFO pointers and keep the entry count.
    // NOTE: sequential state is always assigned with <= so every register samples the pre-edge values of its inputs.
    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (!push && pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Load the register-file write port from the head entry when it is free.
    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            regWriteQ  <= 1'b0;
            writeRegQ  <= '0;
            writeDataQ <= '0;
        end else begin
            regWriteQ <= pop;
            if (pop) begin
                writeRegQ  <= mem[head].addr;
                writeDataQ <= mem[head].data;
            end
        end
    end

    // Drain FSM state register.
    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            state <= RUN;
        end else begin
            state <= stateNext;
        end
    end

    // Drain FSM next state: a drain finishes only once the last write has left the output stage.
    always_comb begin
        stateNext = state;
        case (state)
            RUN:     if (bus.drain_req) stateNext = DRAIN;
            DRAIN:   if ((count == '0) && !regWriteQ) stateNext = DONE;
            DONE:    stateNext = RUN;
            default: stateNext = RUN;
        endcase
    end

    assign bus.wb_ready   = wbReady;
    assign bus.regWrite   = regWriteQ;
    assign bus.writeReg   = writeRegQ;
    assign bus.writeData  = writeDataQ;
    assign bus.drain_done = (state == DONE);
    assign bus.occupancy  = count;

`ifdef WBQ_FWD_EN
    logic              fwdHit1;
    logic              fwdHit2;
    logic [DATA_W-1:0] fwdData1;
    logic [DATA_W-1:0] fwdData2;

    wbq_fwd_match #(.DEPTH(DEPTH)) fwdMatch1 (
        .entries  (mem),
        .head     (head),
        .count    (count),
        .outValid (regWriteQ),
        .outAddr  (writeRegQ),
        .outData  (writeDataQ),
        .readReg  (bus.readReg1),
        .hit      (fwdHit1),
        .data     (fwdData1)
    );

    wbq_fwd_match #(.DEPTH(DEPTH)) fwdMatch2 (
        .entries  (mem),
        .head     (head),
        .count    (count),
        .outValid (regWriteQ),
        .outAddr  (writeRegQ),
        .outData  (writeDataQ),
        .readReg  (bus.readReg2),
        .hit      (fwdHit2),
        .data     (fwdData2)
    );

    assign bus.fwd_hit1  = fwdHit1;
    assign bus.fwd_hit2  = fwdHit2;
    assign bus.fwd_data1 = fwdData1;
    assign bus.fwd_data2 = fwdData2;
`else
    // Read indices have no consumer without forwarding.
    logic unusedReadRegs;
    assign unusedReadRegs = ^{bus.readReg1, bus.readReg2};

    assign bus.fwd_hit1  = 1'b0;
    assign bus.fwd_hit2  = 1'b0;
    assign bus.fwd_data1 = '0;
    assign bus.fwd_data2 = '0;
`endif

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Self-checking bench for reg_writeback_queue: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_reg_writeback_queue;

    localparam int DEPTH = 4;
`ifdef WBQ_FWD_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    logic clock_in = 1'b0;
    logic reset    = 1'b0;
    always #5 clock_in = ~clock_in;

    reg_writeback_queue_if #(.DEPTH(DEPTH)) bus ();

    reg_writeback_queue #(.DEPTH(DEPTH)) dut (
        .clock_in (clock_in),
        .reset    (reset),
        .bus      (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: pending writes as a plain queue, the output stage, and the drain phase.
    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ment_t;

    ment_t       mq[$];
    logic        mRegWrite;
    logic [4:0]  mWriteReg;
    logic [31:0] mWriteData;
    int          mPhase;   // 0 = accepting, 1 = draining, 2 = drain finished

    task automatic modelReset();
        mq.delete();
        mRegWrite  = 1'b0;
        mWriteReg  = '0;
        mWriteData = '0;
        mPhase     = 0;
    endtask

    function automatic bit modelReady();
        return (mPhase == 0) && (mq.size() < DEPTH);
    endfunction

    function automatic void expFwd(input logic [4:0] r, output logic h, output logic [31:0] d);
        h = 1'b0;
        d = '0;
        if (FWD_ON && (r != 5'd0)) begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (!h && (mq[i].a == r)) begin
                    h = 1'b1;
                    d = mq[i].d;
                end
            end
            if (!h && mRegWrite && (mWriteReg == r)) begin
                h = 1'b1;
                d = mWriteData;
            end
        end
    endfunction

    task automatic idle();
        bus.wb_valid  = 1'b0;
        bus.wb_reg    = '0;
        bus.wb_data   = '0;
        bus.rf_busy   = 1'b0;
        bus.readReg1  = '0;
        bus.readReg2  = '0;
        bus.drain_req = 1'b0;
    endtask

    // One clock: model consumes the pre-edge inputs, then we land 1 time unit after the edge.
    task automatic tick();
        bit          acc;
        bit          doPop;
        int          ph;
        logic [4:0]  nr;
        logic [31:0] nd;
        ment_t       e;
        acc   = bus.wb_valid && modelReady();
        doPop = (mq.size() > 0) && !bus.rf_busy;
        nr    = bus.wb_reg;
        nd    = bus.wb_data;
        ph    = mPhase;
        case (mPhase)
            0:       if (bus.drain_req) ph = 1;
            1:       if ((mq.size() == 0) && !mRegWrite) ph = 2;
            default: ph = 0;
        endcase
        @(posedge clock_in);
        if (!reset) begin
            modelReset();
        end else begin
            if (doPop) begin
                e          = mq.pop_front();
                mRegWrite  = 1'b1;
                mWriteReg  = e.a;
                mWriteData = e.d;
            end else begin
                mRegWrite = 1'b0;
            end
            if (acc && (nr != 5'd0)) mq.push_back('{a: nr, d: nd});
            mPhase = ph;
        end
        #1;
    endtask

    task automatic push(input logic [4:0] r, input logic [31:0] d);
        bus.wb_valid = 1'b1;
        bus.wb_reg   = r;
        bus.wb_data  = d;
        tick();
        bus.wb_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b0;
        modelReset();
        tick();
        tick();
        total++; if (bus.occupancy !== 3'd0) begin bad++; $display("FAIL reset_occ: got %0d want 0", bus.occupancy); end
        total++; if (bus.regWrite !== 1'b0) begin bad++; $display("FAIL reset_regWrite: got %b want 0", bus.regWrite); end
        total++; if (bus.writeData !== 32'h0 || bus.writeReg !== 5'd0) begin bad++; $display("FAIL reset_wport: got %0h/%0h want 0/0", bus.writeReg, bus.writeData); end
        total++; if (bus.wb_ready !== 1'b1 || bus.drain_done !== 1'b0) begin bad++; $display("FAIL reset_ready_done: got %b%b want 10", bus.wb_ready, bus.drain_done); end
        reset = 1'b1;
        push(5'd3, 32'hA5A5A5A5);
        tick();
        total++; if (bus.regWrite !== 1'b1 || bus.writeData !== 32'hA5A5A5A5) begin bad++; $display("FAIL pre_reset_write: got %b/%0h want 1/a5a5a5a5", bus.regWrite, bus.writeData); end
        bus.rf_busy = 1'b1;
        push(5'd4, 32'h4);
        push(5'd5, 32'h5);
        push(5'd6, 32'h6);
        total++; if (bus.occupancy !== 3'd3) begin bad++; $display("FAIL three_queued: got %0d want 3", bus.occupancy); end
        #2 reset = 1'b0;
        #1;
        modelReset();
        total++; if (bus.occupancy !== 3'd0 || bus.regWrite !== 1'b0 || bus.writeData !== 32'h0) begin
            bad++; $display("FAIL async_reset: got occ=%0d rw=%b wd=%0h want 0/0/0", bus.occupancy, bus.regWrite, bus.writeData);
        end
        tick();
        reset = 1'b1;
        idle();
        tick();
        tick();
        total++; if (bus.occupancy !== 3'd0 || bus.regWrite !== 1'b0) begin bad++; $display("FAIL reset_discard: got occ=%0d rw=%b want 0/0", bus.occupancy, bus.regWrite); end
    endtask

    task automatic test_in_order();
        idle();
        push(5'd21, 32'hFFFF0000);
        total++; if (bus.occupancy !== 3'd1 || bus.regWrite !== 1'b0) begin bad++; $display("FAIL order_lat: got occ=%0d rw=%b want 1/0", bus.occupancy, bus.regWrite); end
        push(5'd10, 32'h0000FFFF);
        total++; if ({bus.regWrite, bus.writeReg, bus.writeData} !== {1'b1, 5'd21, 32'hFFFF0000}) begin
            bad++; $display("FAIL order_first: got %b/%0d/%0h want 1/21/ffff0000", bus.regWrite, bus.writeReg, bus.writeData);
        end
        tick();
        total++; if ({bus.regWrite, bus.writeReg, bus.writeData} !== {1'b1, 5'd10, 32'h0000FFFF}) begin
            bad++; $display("FAIL order_second: got %b/%0d/%0h want 1/10/ffff", bus.regWrite, bus.writeReg, bus.writeData);
        end
        tick();
        total++; if (bus.regWrite !== 1'b0 || bus.writeData !== 32'h0000FFFF || bus.occupancy !== 3'd0) begin
            bad++; $display("FAIL order_hold: got rw=%b wd=%0h occ=%0d want 0/ffff/0", bus.regWrite, bus.writeData, bus.occupancy);
        end
    endtask

    task automatic test_full();
        ment_t got[$];
        bit    acc;
        idle();
        bus.rf_busy = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            total++; if (bus.wb_ready !== 1'b1) begin bad++; $display("FAIL full_ready_%0d: got %b want 1", i, bus.wb_ready); end
            push(5'(i + 1), 32'h100 + 32'(i));
        end
        total++; if (bus.occupancy !== 3'd4 || bus.wb_ready !== 1'b0) begin bad++; $display("FAIL full_state: got occ=%0d rdy=%b want 4/0", bus.occupancy, bus.wb_ready); end
        bus.wb_valid = 1'b1;
        bus.wb_reg   = 5'd5;
        bus.wb_data  = 32'h104;
        tick();
        tick();
        total++; if (bus.occupancy !== 3'd4 || bus.regWrite !== 1'b0) begin bad++; $display("FAIL full_stall: got occ=%0d rw=%b want 4/0", bus.occupancy, bus.regWrite); end
        bus.rf_busy = 1'b0;
        for (int c = 0; c < 20 && got.size() < 5; c++) begin
            if (c == 0) begin
                total++; if (bus.wb_ready !== 1'b0) begin bad++; $display("FAIL full_deq_no_accept: got %b want 0", bus.wb_ready); end
            end
            acc = bus.wb_valid && modelReady();
            tick();
            if (acc) bus.wb_valid = 1'b0;
            if (bus.regWrite === 1'b1) got.push_back('{a: bus.writeReg, d: bus.writeData});
        end
        total++; if (got.size() != 5) begin bad++; $display("FAIL full_count: got %0d writes want 5", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            total++; if (got[i].a !== 5'(i + 1) || got[i].d !== 32'h100 + 32'(i)) begin
                bad++; $display("FAIL full_order_%0d: got %0d/%0h want %0d/%0h", i, got[i].a, got[i].d, i + 1, 32'h100 + 32'(i));
            end
        end
        idle();
        tick();
    endtask

    task automatic test_fwd();
        idle();
        bus.rf_busy = 1'b1;
        push(5'd21, 32'h1);
        push(5'd21, 32'h2);
        bus.readReg1 = 5'd21;
        bus.readReg2 = 5'd0;
        #1;
        total++; if (bus.fwd_hit1 !== FWD_ON || bus.fwd_data1 !== (FWD_ON ? 32'h2 : 32'h0)) begin
            bad++; $display("FAIL fwd_newest: got %b/%0h want %b/%0h", bus.fwd_hit1, bus.fwd_data1, FWD_ON, FWD_ON ? 32'h2 : 32'h0);
        end
        total++; if (bus.fwd_hit2 !== 1'b0 || bus.fwd_data2 !== 32'h0) begin bad++; $display("FAIL fwd_r0: got %b/%0h want 0/0", bus.fwd_hit2, bus.fwd_data2); end
        bus.rf_busy = 1'b0;
        tick();
        tick();
        total++; if (bus.fwd_hit1 !== FWD_ON || bus.fwd_data1 !== (FWD_ON ? 32'h2 : 32'h0) || bus.occupancy !== 3'd0) begin
            bad++; $display("FAIL fwd_outstage: got %b/%0h occ=%0d want %b/%0h occ=0", bus.fwd_hit1, bus.fwd_data1, bus.occupancy, FWD_ON, FWD_ON ? 32'h2 : 32'h0);
        end
        tick();
        total++; if (bus.fwd_hit1 !== 1'b0 || bus.fwd_data1 !== 32'h0) begin bad++; $display("FAIL fwd_gone: got %b/%0h want 0/0", bus.fwd_hit1, bus.fwd_data1); end
        idle();
    endtask

    task automatic test_r0();
        idle();
        total++; if (bus.wb_ready !== 1'b1) begin bad++; $display("FAIL r0_ready: got %b want 1", bus.wb_ready); end
        push(5'd0, 32'hDEAD);
        total++; if (bus.occupancy !== 3'd0) begin bad++; $display("FAIL r0_occ: got %0d want 0", bus.occupancy); end
        tick();
        total++; if (bus.regWrite !== 1'b0) begin bad++; $display("FAIL r0_nowrite: got %b want 0", bus.regWrite); end
    endtask

    task automatic test_drain();
        int pulses;
        int after;
        idle();
        bus.rf_busy = 1'b1;
        push(5'd7, 32'h77);
        push(5'd8, 32'h88);
        bus.drain_req = 1'b1;
        tick();
        bus.drain_req = 1'b0;
        tick();
        total++; if (bus.wb_ready !== 1'b0 || bus.occupancy !== 3'd2) begin bad++; $display("FAIL drain_block: got rdy=%b occ=%0d want 0/2", bus.wb_ready, bus.occupancy); end
        bus.rf_busy = 1'b0;
        pulses = 0;
        after  = 0;
        for (int c = 0; c < 20 && after < 2; c++) begin
            tick();
            total++; if (bus.wb_ready !== modelReady() || bus.drain_done !== (mPhase == 2)) begin
                bad++; $display("FAIL drain_cycle_%0d: got rdy=%b done=%b want %b/%b", c, bus.wb_ready, bus.drain_done, modelReady(), mPhase == 2);
            end
            if (bus.drain_done === 1'b1) pulses++;
            if (pulses > 0) after++;
        end
        total++; if (pulses != 1) begin bad++; $display("FAIL drain_pulses: got %0d want 1", pulses); end
        total++; if (bus.wb_ready !== 1'b1 || bus.occupancy !== 3'd0) begin bad++; $display("FAIL drain_resume: got rdy=%b occ=%0d want 1/0", bus.wb_ready, bus.occupancy); end
    endtask

    task automatic test_random();
        logic        h1, h2;
        logic [31:0] d1, d2;
        for (int c = 0; c < 400; c++) begin
            bus.wb_valid  = ($urandom_range(0, 99) < 60);
            bus.wb_reg    = 5'($urandom_range(0, 7));
            bus.wb_data   = $urandom;
            bus.rf_busy   = ($urandom_range(0, 99) < 30);
            bus.drain_req = ($urandom_range(0, 99) < 4);
            bus.readReg1  = 5'($urandom_range(0, 7));
            bus.readReg2  = 5'($urandom_range(0, 7));
            #1;
            expFwd(bus.readReg1, h1, d1);
            expFwd(bus.readReg2, h2, d2);
            total++; if ({bus.wb_ready, bus.fwd_hit1, bus.fwd_data1, bus.fwd_hit2, bus.fwd_data2} !== {modelReady(), h1, d1, h2, d2}) begin
                bad++; $display("FAIL rand_comb_%0d: got rdy=%b %b/%0h %b/%0h want %b %b/%0h %b/%0h", c, bus.wb_ready,
                                bus.fwd_hit1, bus.fwd_data1, bus.fwd_hit2, bus.fwd_data2, modelReady(), h1, d1, h2, d2);
            end
            tick();
            total++; if ({bus.regWrite, bus.writeReg, bus.writeData, bus.occupancy, bus.drain_done} !==
                         {mRegWrite, mWriteReg, mWriteData, 3'(mq.size()), (mPhase == 2)}) begin
                bad++; $display("FAIL rand_seq_%0d: got %b/%0d/%0h occ=%0d done=%b want %b/%0d/%0h occ=%0d done=%b", c,
                                bus.regWrite, bus.writeReg, bus.writeData, bus.occupancy, bus.drain_done,
                                mRegWrite, mWriteReg, mWriteData, mq.size(), mPhase == 2);
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_full();
        test_fwd();
        test_r0();
        test_drain();
        test_random();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
